mode_counter: RTL and testbench

//   Parametrised up/down counter with runtime-selectable overflow mode (wrap,

---
 rtl/mode_counter.sv | 137 +++++++++++++
 tb/tb_mode_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Up/down counter with selectable overflow behaviour (wrap, saturate, modulo-N, one-shot),
// programmable step, clamped parallel load, registered terminal-count pulse and sticky overflow.
module mode_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              done
);

    typedef enum logic [1:0] {
        WRAP    = 2'b00,
        SAT     = 2'b01,
        MODN    = 2'b10,
        ONESHOT = 2'b11
    } mode_t;

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    mode_t          m;
    logic [WIDTH:0] c1, lim1, lim_p1, stp1, se1;
    logic [WIDTH:0] sum, dif, msum, mwrap, mdif, mdn;
    logic [WIDTH-1:0] nxt;
    logic           evt, adv;

    assign m      = mode_t'(mode);
    assign c1     = {1'b0, count};
    assign lim1   = {1'b0, limit};
    assign lim_p1 = lim1 + ONE;
    assign stp1   = {{(WIDTH+1-STEP_W){1'b0}}, step};
    // Modulo step never exceeds one full period, so a single fold-back suffices.
    assign se1    = (stp1 > lim_p1) ? lim_p1 : stp1;

    assign sum    = c1 + stp1;
    assign dif    = c1 - stp1;
    assign msum   = c1 + se1;
    assign mwrap  = msum - lim_p1;
    assign mdif   = c1 + lim_p1 - se1;
    assign mdn    = c1 - se1;

    always_comb begin
        nxt = count;
        evt = 1'b0;
        if (step != '0) begin
            case (m)
                WRAP: begin
                    if (dir) begin
                        nxt = sum[WIDTH-1:0];
                        evt = sum[WIDTH];
                    end else begin
                        nxt = dif[WIDTH-1:0];
                        evt = dif[WIDTH];
                    end
                end
                MODN: begin
                    if (c1 > lim1) begin
                        nxt = limit;
                        evt = 1'b1;
                    end else if (dir) begin
                        if (msum > lim1) begin
                            nxt = mwrap[WIDTH-1:0];
                            evt = 1'b1;
                        end else begin
                            nxt = msum[WIDTH-1:0];
                        end
                    end else begin
                        if (c1 < se1) begin
                            nxt = mdif[WIDTH-1:0];
                            evt = 1'b1;
                        end else begin
                            nxt = mdn[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    // SAT and ONESHOT share the clamping arithmetic.
                    if (dir) begin
                        if (sum >= lim1) begin
                            nxt = limit;
                            evt = 1'b1;
                        end else begin
                            nxt = sum[WIDTH-1:0];
                        end
                    end else begin
                        if (c1 <= stp1) begin
                            nxt = '0;
                            evt = 1'b1;
                        end else begin
                            nxt = dif[WIDTH-1:0];
                        end
                    end
                end
            endcase
        end
    end

    assign adv = !load && en && !(m == ONESHOT && done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= (m != WRAP && load_val > limit) ? limit : load_val;
                done  <= 1'b0;
            end else if (adv) begin
                count <= nxt;
                tc    <= evt;
                if (m == ONESHOT && evt)
                    done <= 1'b1;
            end
            if (m != ONESHOT)
                done <= 1'b0;
            if (adv && evt)
                ovf <= 1'b1;
            else if (clr_flags)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: stimulus queues hand-computed expectations,
// a monitor pops one per clock and compares against the registered outputs.
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, dir, load, clr_flags;
    logic [1:0] mode;
    logic [3:0] step;
    logic [7:0] limit, load_val;
    logic [7:0] count;
    logic       tc, ovf, done;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      nm;
        logic [7:0] c;
        logic       t;
        logic       o;
        logic       d;
    } exp_t;

    exp_t q[$];

    localparam logic [1:0] MW = 2'b00, MS = 2'b01, MM = 2'b10, MO = 2'b11;

    mode_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .step(step),
        .limit(limit), .load(load), .load_val(load_val), .clr_flags(clr_flags),
        .count(count), .tc(tc), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] c, input logic t, input logic o,
                       input logic d);
        n_chk++;
        if (count !== c || tc !== t || ovf !== o || done !== d) begin
            n_fail++;
            $display("FAIL %s: got count=%h tc=%b ovf=%b done=%b, want count=%h tc=%b ovf=%b done=%b",
                     nm, count, tc, ovf, done, c, t, o, d);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, e.c, e.t, e.o, e.d);
        end
    end

    task automatic cyc(input string nm, input logic ld, input logic [7:0] lv, input logic e,
                       input logic d, input logic [1:0] md, input logic [3:0] st,
                       input logic [7:0] lm, input logic clr, input logic [7:0] ec,
                       input logic et, input logic eo, input logic ed);
        exp_t x;
        @(negedge clk);
        load = ld; load_val = lv; en = e; dir = d; mode = md; step = st; limit = lm;
        clr_flags = clr;
        x.nm = nm; x.c = ec; x.t = et; x.o = eo; x.d = ed;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 0; dir = 0; load = 0; clr_flags = 0;
        mode = MW; step = 0; limit = 0; load_val = 0;
        #3 chk("reset_state", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 1'b1;

        //   name          ld lv     en dir mode st lim    clr  count  tc ovf done
        // T1: wrap across 0xFF
        cyc("t1_load",     1, 8'hFE, 0, 1, MW, 1, 8'h00, 0,   8'hFE, 0, 0, 0);
        cyc("t1_ff",       0, 8'h00, 1, 1, MW, 1, 8'h00, 0,   8'hFF, 0, 0, 0);
        cyc("t1_00",       0, 8'h00, 1, 1, MW, 1, 8'h00, 0,   8'h00, 1, 1, 0);
        cyc("t1_01",       0, 8'h00, 1, 1, MW, 1, 8'h00, 0,   8'h01, 0, 1, 0);
        cyc("t1_clr",      0, 8'h00, 0, 1, MW, 1, 8'h00, 1,   8'h01, 0, 0, 0);
        cyc("wrap_down",   0, 8'h00, 1, 0, MW, 2, 8'h00, 0,   8'hFF, 1, 1, 0);
        cyc("wrap_clr",    0, 8'h00, 0, 0, MW, 2, 8'h00, 1,   8'hFF, 0, 0, 0);
        // T2: saturate
        cyc("t2_load",     1, 8'h08, 0, 1, MS, 3, 8'd10, 0,   8'd8,  0, 0, 0);
        cyc("t2_up_clamp", 0, 8'h00, 1, 1, MS, 3, 8'd10, 0,   8'd10, 1, 1, 0);
        cyc("t2_held",     0, 8'h00, 1, 1, MS, 3, 8'd10, 0,   8'd10, 1, 1, 0);
        cyc("t2_load2",    1, 8'h02, 0, 0, MS, 4, 8'd10, 0,   8'd2,  0, 1, 0);
        cyc("t2_dn_clamp", 0, 8'h00, 1, 0, MS, 4, 8'd10, 0,   8'd0,  1, 1, 0);
        cyc("set_over_clr",0, 8'h00, 1, 0, MS, 1, 8'd10, 1,   8'd0,  1, 1, 0);
        cyc("sat_clr",     0, 8'h00, 0, 0, MS, 1, 8'd10, 1,   8'd0,  0, 0, 0);
        cyc("step_zero",   0, 8'h00, 1, 0, MS, 0, 8'd10, 0,   8'd0,  0, 0, 0);
        cyc("sat_up3",     0, 8'h00, 1, 1, MS, 3, 8'd10, 0,   8'd3,  0, 0, 0);
        // T3: modulo
        cyc("t3_load",     1, 8'h07, 0, 1, MM, 4, 8'd9,  0,   8'd7,  0, 0, 0);
        cyc("t3_up_wrap",  0, 8'h00, 1, 1, MM, 4, 8'd9,  0,   8'd1,  1, 1, 0);
        cyc("t3_dn_wrap",  0, 8'h00, 1, 0, MM, 3, 8'd9,  0,   8'd8,  1, 1, 0);
        cyc("mod_to_lim",  0, 8'h00, 1, 1, MM, 1, 8'd9,  1,   8'd9,  0, 0, 0);
        cyc("mod_bigstep", 0, 8'h00, 1, 1, MM, 15, 8'd9, 0,   8'd9,  1, 1, 0);
        cyc("mod_clr",     0, 8'h00, 0, 1, MM, 1, 8'd9,  1,   8'd9,  0, 0, 0);
        cyc("mod_lim0_a",  0, 8'h00, 1, 1, MM, 3, 8'd0,  0,   8'd0,  1, 1, 0);
        cyc("mod_lim0_b",  0, 8'h00, 1, 0, MM, 3, 8'd0,  0,   8'd0,  1, 1, 0);
        cyc("mod_clr2",    0, 8'h00, 0, 0, MM, 3, 8'd0,  1,   8'd0,  0, 0, 0);
        cyc("wrap_ld50",   1, 8'h50, 0, 1, MW, 1, 8'h20, 0,   8'h50, 0, 0, 0);
        cyc("mod_entry",   0, 8'h00, 1, 1, MM, 1, 8'h20, 0,   8'h20, 1, 1, 0);
        cyc("mod_clr3",    0, 8'h00, 0, 1, MM, 1, 8'h20, 1,   8'h20, 0, 0, 0);
        // T4: one-shot
        cyc("t4_load",     1, 8'h00, 0, 1, MO, 2, 8'd5,  0,   8'd0,  0, 0, 0);
        cyc("t4_2",        0, 8'h00, 1, 1, MO, 2, 8'd5,  0,   8'd2,  0, 0, 0);
        cyc("t4_4",        0, 8'h00, 1, 1, MO, 2, 8'd5,  0,   8'd4,  0, 0, 0);
        cyc("t4_5_done",   0, 8'h00, 1, 1, MO, 2, 8'd5,  0,   8'd5,  1, 1, 1);
        cyc("t4_hold_a",   0, 8'h00, 1, 1, MO, 2, 8'd5,  0,   8'd5,  0, 1, 1);
        cyc("t4_hold_b",   0, 8'h00, 1, 0, MO, 2, 8'd5,  0,   8'd5,  0, 1, 1);
        cyc("os_load",     1, 8'h03, 0, 0, MO, 2, 8'd5,  0,   8'd3,  0, 1, 0);
        cyc("os_dn1",      0, 8'h00, 1, 0, MO, 2, 8'd5,  0,   8'd1,  0, 1, 0);
        cyc("os_dn0",      0, 8'h00, 1, 0, MO, 2, 8'd5,  0,   8'd0,  1, 1, 1);
        cyc("os_leave",    0, 8'h00, 0, 0, MW, 2, 8'd5,  0,   8'd0,  0, 1, 0);
        cyc("os_clr",      0, 8'h00, 0, 0, MW, 2, 8'd5,  1,   8'd0,  0, 0, 0);
        // T5: load beats en, clamps outside WRAP only
        cyc("t5_mod",      1, 8'h30, 1, 1, MM, 1, 8'h20, 0,   8'h20, 0, 0, 0);
        cyc("t5_wrap",     1, 8'h30, 1, 1, MW, 1, 8'h20, 0,   8'h30, 0, 0, 0);
        // T6: async reset mid-count
        cyc("t6_ldff",     1, 8'hFF, 0, 1, MW, 1, 8'h00, 0,   8'hFF, 0, 0, 0);
        cyc("t6_wrap",     0, 8'h00, 1, 1, MW, 1, 8'h00, 0,   8'h00, 1, 1, 0);
        cyc("t6_ld37",     1, 8'h37, 0, 1, MW, 1, 8'h00, 0,   8'h37, 0, 1, 0);
        @(negedge clk);
        load = 1; load_val = 8'h99; en = 1; rst = 1'b0;
        #2 chk("t6_async_rst", 8'h00, 0, 0, 0);
        @(posedge clk); #1 chk("t6_rst_held", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 1'b1; load = 0; en = 0;
        cyc("t6_after",    0, 8'h00, 0, 1, MW, 1, 8'h00, 0,   8'h00, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
